// File: rtl/parser_check_pkg.sv
// parser_check_pkg: shared state encodings and error-cause bit positions for the parser sequence checker
package parser_check_pkg;
  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_CHECK = 4'd1;
  localparam logic [3:0] ST_PASS  = 4'd2;
  localparam logic [3:0] ST_FAIL  = 4'd15;
  localparam int ERR_DATA = 0;
  localparam int ERR_BV   = 1;
  localparam int ERR_CHAN = 2;
  localparam int ERR_OVR  = 3;
endpackage

// File: rtl/parser_check_table.sv
// parser_check_table: expected-beat register file, one sync write port, combinational read
module parser_check_table #(
  parameter int DATA_W = 64,
  parameter int BV_W   = DATA_W/8,
  parameter int CHAN   = 16,
  parameter int DEPTH  = 16,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BV_W-1:0]   wbv,
  input  logic [CHAN-1:0]   wchan,
  input  logic [IDX_W-1:0]  ridx,
  output logic [DATA_W-1:0] rdata,
  output logic [BV_W-1:0]   rbv,
  output logic [CHAN-1:0]   rchan
);
  localparam int ENT_W = DATA_W + BV_W + CHAN;
  logic [ENT_W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem_q[widx] <= {wchan, wbv, wdata};
  end
  assign {rchan, rbv, rdata} = mem_q[ridx];
endmodule

// File: rtl/parser_seq_check.sv
// parser_seq_check: compares parser output beats against a programmable expected-beat sequence
module parser_seq_check
  import parser_check_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int BV_W   = DATA_W/8,
  parameter int ADDR_W = 9,
  parameter int CHAN   = 16,
  parameter int DEPTH  = 16,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic [BV_W-1:0]   cfg_bv,
  input  logic [CHAN-1:0]   cfg_chan,
  input  logic [IDX_W:0]    cfg_len,
  input  logic              start,
  input  logic [DATA_W-1:0] data_out,
  input  logic [BV_W-1:0]   byte_valid,
  input  logic [ADDR_W-1:0] address,
  input  logic [CHAN-1:0]   valid,
  output logic [3:0]        state_out,
  output logic [IDX_W:0]    match_cnt,
  output logic              err_flag,
  output logic [IDX_W-1:0]  err_idx,
  output logic [3:0]        err_field,
  output logic [ADDR_W-1:0] err_addr,
  output logic              done
);
  localparam logic [IDX_W:0] LEN_MAX = (IDX_W+1)'(DEPTH);
  localparam logic [3:0] OVR_ONLY = 4'b1 << ERR_OVR;
  logic [3:0] state_q, state_d, state_out_q;
  logic [IDX_W:0] ptr_q, ptr_d, len_q, len_d, match_cnt_q, match_cnt_d;
  logic err_flag_q, err_flag_d;
  logic [IDX_W-1:0] err_idx_q, err_idx_d;
  logic [3:0] err_field_q, err_field_d, miss;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;
  logic [DATA_W-1:0] e_data, data_mask;
  logic [BV_W-1:0] e_bv;
  logic [CHAN-1:0] e_chan;
  logic beat;
  parser_check_table #(
    .DATA_W(DATA_W), .BV_W(BV_W), .CHAN(CHAN), .DEPTH(DEPTH), .IDX_W(IDX_W)
  ) u_table (
    .clk   (clk),
    .we    (cfg_we && state_q != ST_CHECK),
    .widx  (cfg_idx),
    .wdata (cfg_data),
    .wbv   (cfg_bv),
    .wchan (cfg_chan),
    .ridx  (ptr_q[IDX_W-1:0]),
    .rdata (e_data),
    .rbv   (e_bv),
    .rchan (e_chan)
  );
  for (genvar b = 0; b < BV_W; b++) begin : g_mask
    assign data_mask[b*8 +: 8] = {8{e_bv[b]}};
  end
  assign beat = |valid;
  always_comb begin
    miss = '0;
    miss[ERR_DATA] = |((data_out ^ e_data) & data_mask);
    miss[ERR_BV]   = byte_valid != e_bv;
    miss[ERR_CHAN] = valid != e_chan;
  end
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    len_d = len_q;
    match_cnt_d = match_cnt_q;
    err_flag_d = err_flag_q;
    err_idx_d = err_idx_q;
    err_field_d = err_field_q;
    err_addr_d = err_addr_q;
    if (start) begin
      state_d = cfg_len == '0 ? ST_PASS : ST_CHECK;
      ptr_d = '0;
      len_d = cfg_len > LEN_MAX ? LEN_MAX : cfg_len;
      match_cnt_d = '0;
      err_flag_d = 1'b0;
      err_idx_d = '0;
      err_field_d = '0;
      err_addr_d = '0;
    end else if (beat && state_q == ST_CHECK && |miss) begin
      state_d = ST_FAIL;
      err_flag_d = 1'b1;
      err_idx_d = ptr_q[IDX_W-1:0];
      err_field_d = miss;
      err_addr_d = address;
    end else if (beat && state_q == ST_CHECK) begin
      match_cnt_d = match_cnt_q + 1'b1;
      ptr_d = ptr_q + 1'b1;
      state_d = ptr_q == len_q - 1'b1 ? ST_PASS : ST_CHECK;
    end else if (beat && state_q == ST_PASS) begin
      // a beat after the whole sequence matched is an overrun
      state_d = ST_FAIL;
      err_flag_d = 1'b1;
      err_idx_d = len_q[IDX_W-1:0];
      err_field_d = OVR_ONLY;
      err_addr_d = address;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      state_out_q <= ST_IDLE;
      ptr_q <= '0;
      len_q <= '0;
      match_cnt_q <= '0;
      err_flag_q <= 1'b0;
      err_idx_q <= '0;
      err_field_q <= '0;
      err_addr_q <= '0;
    end else begin
      state_q <= state_d;
      state_out_q <= state_q;
      ptr_q <= ptr_d;
      len_q <= len_d;
      match_cnt_q <= match_cnt_d;
      err_flag_q <= err_flag_d;
      err_idx_q <= err_idx_d;
      err_field_q <= err_field_d;
      err_addr_q <= err_addr_d;
    end
  end
  assign state_out = state_out_q;
  assign match_cnt = match_cnt_q;
  assign err_flag = err_flag_q;
  assign err_idx = err_idx_q;
  assign err_field = err_field_q;
  assign err_addr = err_addr_q;
  assign done = state_q == ST_PASS || state_q == ST_FAIL;
endmodule

// File: tb/tb_parser_seq_check.sv
// tb_parser_seq_check: directed and random checks against a behavioural sequence-checker model
module tb_parser_seq_check;
  localparam int DEPTH = 16;
  logic clk = 0, rst = 1;
  logic cfg_we = 0, start = 0;
  logic [3:0] cfg_idx = 0;
  logic [63:0] cfg_data = 0, data_out = 0;
  logic [7:0] cfg_bv = 0, byte_valid = 0;
  logic [15:0] cfg_chan = 0, valid = 0;
  logic [4:0] cfg_len = 0;
  logic [8:0] address = 0;
  logic [3:0] state_out, err_idx, err_field;
  logic [4:0] match_cnt;
  logic err_flag, done;
  logic [8:0] err_addr;

  always #5 clk = ~clk;

  parser_seq_check dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_data(cfg_data),
    .cfg_bv(cfg_bv), .cfg_chan(cfg_chan), .cfg_len(cfg_len), .start(start),
    .data_out(data_out), .byte_valid(byte_valid), .address(address), .valid(valid),
    .state_out(state_out), .match_cnt(match_cnt), .err_flag(err_flag), .err_idx(err_idx),
    .err_field(err_field), .err_addr(err_addr), .done(done)
  );

  int checks = 0, errors = 0;
  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: expected table plus checker status, stepped once per clock
  logic [63:0] t_data [DEPTH];
  logic [7:0]  t_bv   [DEPTH];
  logic [15:0] t_chan [DEPTH];
  int m_state = 0, m_sout = 0, m_ptr = 0, m_len = 0, m_match = 0, m_eidx = 0;
  bit m_eflag = 0;
  logic [3:0] m_efield = 0;
  logic [8:0] m_eaddr = 0;

  always @(posedge clk) begin : model
    logic [3:0] f;
    m_sout = rst ? 0 : m_state;
    if (cfg_we && m_state != 1) begin
      t_data[cfg_idx] = cfg_data;
      t_bv[cfg_idx] = cfg_bv;
      t_chan[cfg_idx] = cfg_chan;
    end
    if (rst) begin
      m_state = 0; m_ptr = 0; m_len = 0; m_match = 0;
      m_eflag = 0; m_eidx = 0; m_efield = 0; m_eaddr = 0;
    end else if (start) begin
      m_len = cfg_len > DEPTH ? DEPTH : int'(cfg_len);
      m_ptr = 0; m_match = 0; m_eflag = 0; m_eidx = 0; m_efield = 0; m_eaddr = 0;
      m_state = cfg_len == 0 ? 2 : 1;
    end else if (valid != 0 && m_state == 1) begin
      f = 0;
      for (int i = 0; i < 8; i++)
        if (t_bv[m_ptr][i] && data_out[8*i +: 8] != t_data[m_ptr][8*i +: 8]) f[0] = 1;
      f[1] = byte_valid != t_bv[m_ptr];
      f[2] = valid != t_chan[m_ptr];
      if (f != 0) begin
        m_state = 15; m_eflag = 1; m_eidx = m_ptr; m_efield = f; m_eaddr = address;
      end else begin
        m_match++;
        m_ptr++;
        if (m_ptr == m_len) m_state = 2;
      end
    end else if (valid != 0 && m_state == 2) begin
      m_state = 15; m_eflag = 1; m_eidx = m_len % DEPTH; m_efield = 4'b1000; m_eaddr = address;
    end
  end

  always @(negedge clk) begin
    check("state_out", state_out, m_sout);
    check("match_cnt", match_cnt, m_match);
    check("err_flag", err_flag, m_eflag);
    check("err_idx", err_idx, m_eidx);
    check("err_field", err_field, m_efield);
    check("err_addr", err_addr, m_eaddr);
    check("done", done, m_state == 2 || m_state == 15);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wr(int idx, logic [63:0] d, logic [7:0] bv, logic [15:0] ch);
    cfg_we = 1; cfg_idx = 4'(idx); cfg_data = d; cfg_bv = bv; cfg_chan = ch;
    tick();
    cfg_we = 0;
  endtask
  task automatic arm(int len);
    start = 1; cfg_len = 5'(len);
    tick();
    start = 0;
  endtask
  task automatic send(logic [63:0] d, logic [7:0] bv, logic [15:0] ch, logic [8:0] a);
    data_out = d; byte_valid = bv; valid = ch; address = a;
    tick();
    valid = 0;
  endtask
  task automatic send_entry(int i, logic [8:0] a);
    logic [63:0] mask;
    for (int b = 0; b < 8; b++) mask[8*b +: 8] = {8{t_bv[i][b]}};
    send(({$urandom, $urandom} & ~mask) | (t_data[i] & mask), t_bv[i], t_chan[i], a);
  endtask

  localparam logic [63:0] E0_D = 64'h0d0a_0000_0000_0000;
  localparam logic [63:0] E1_D = 64'h1111_2222_3333_4444;

  initial begin
    repeat (2) tick();
    rst = 0;
    check("lit_rst_state_out", state_out, 0);
    check("lit_rst_done", done, 0);
    check("lit_rst_match", match_cnt, 0);
    for (int i = 0; i < DEPTH; i++) wr(i, {$urandom, $urandom}, 8'($urandom), 16'(1) << $urandom_range(0, 15));
    wr(0, E0_D, 8'hc0, 16'h0001);
    wr(1, E1_D, 8'hff, 16'h0002);
    wr(2, E0_D, 8'hc0, 16'h0001);
    // basic pass with don't-care low bytes
    arm(1);
    send(64'h0d0a_dead_beef_1234, 8'hc0, 16'h0001, 9'h012);
    check("lit_pass_done", done, 1);
    check("lit_pass_match", match_cnt, 1);
    check("lit_pass_sout_lag", state_out, 1);
    tick();
    check("lit_pass_sout", state_out, 2);
    // data mismatch, then sticky
    arm(1);
    send(64'h0d0b_0000_0000_0000, 8'hc0, 16'h0001, 9'h055);
    check("lit_data_field", err_field, 4'b0001);
    check("lit_data_idx", err_idx, 0);
    check("lit_data_addr", err_addr, 9'h055);
    send(E0_D, 8'hc0, 16'h0001, 9'h077);
    check("lit_sticky_addr", err_addr, 9'h055);
    // multi-field mismatch on third beat
    arm(3);
    send(E0_D, 8'hc0, 16'h0001, 9'h001);
    send(E1_D, 8'hff, 16'h0002, 9'h002);
    send(E0_D, 8'hff, 16'h0003, 9'h003);
    check("lit_multi_field", err_field, 4'b0110);
    check("lit_multi_idx", err_idx, 2);
    check("lit_multi_match", match_cnt, 2);
    // overrun
    arm(2);
    send(E0_D, 8'hc0, 16'h0001, 9'h010);
    send(E1_D, 8'hff, 16'h0002, 9'h011);
    send(E0_D, 8'hc0, 16'h0001, 9'h1ff);
    check("lit_ovr_field", err_field, 4'b1000);
    check("lit_ovr_idx", err_idx, 2);
    check("lit_ovr_addr", err_addr, 9'h1ff);
    // zero length
    arm(0);
    check("lit_len0_done", done, 1);
    check("lit_len0_flag", err_flag, 0);
    // start wins over same-cycle beat
    start = 1; cfg_len = 1; data_out = E0_D; byte_valid = 8'hc0; valid = 16'h0001;
    tick();
    start = 0; valid = 0;
    check("lit_startbeat_match", match_cnt, 0);
    check("lit_startbeat_done", done, 0);
    send(E0_D, 8'hc0, 16'h0001, 9'h020);
    check("lit_startbeat_pass", done, 1);
    // write dropped while checking
    arm(1);
    wr(0, 64'hffff_ffff_ffff_ffff, 8'hff, 16'h8000);
    send(E0_D, 8'hc0, 16'h0001, 9'h030);
    check("lit_we_drop_done", done, 1);
    check("lit_we_drop_flag", err_flag, 0);
    // reset mid-check, then re-arm from FAIL
    arm(2);
    send(E0_D, 8'hc0, 16'h0001, 9'h040);
    rst = 1;
    tick();
    rst = 0;
    check("lit_rst_mid_match", match_cnt, 0);
    check("lit_rst_mid_done", done, 0);
    check("lit_rst_mid_sout", state_out, 0);
    arm(1);
    send(E1_D, 8'hff, 16'h0002, 9'h041);
    check("lit_fail_flag", err_flag, 1);
    arm(2);
    check("lit_rearm_match", match_cnt, 0);
    check("lit_rearm_flag", err_flag, 0);
    check("lit_rearm_field", err_field, 0);
    tick();
    check("lit_rearm_sout", state_out, 1);
    // saturated length walks the whole table, then overruns
    arm(31);
    for (int i = 0; i < DEPTH; i++) send_entry(i, 9'(i));
    check("lit_sat_match", match_cnt, 16);
    check("lit_sat_done", done, 1);
    send_entry(0, 9'h0aa);
    check("lit_sat_ovr_idx", err_idx, 0);
    check("lit_sat_ovr_field", err_field, 4'b1000);
    // random traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 5) begin
        start = 1; cfg_len = 5'($urandom_range(0, 20));
        valid = ($urandom_range(0, 1) != 0) ? 16'h0001 : 16'h0;
        data_out = {$urandom, $urandom}; byte_valid = 8'($urandom); address = 9'($urandom);
        tick();
        start = 0; valid = 0;
      end else if (r < 8) begin
        wr($urandom_range(0, 15), {$urandom, $urandom}, 8'($urandom), 16'(1) << $urandom_range(0, 15));
      end else if (r == 8) begin
        rst = 1;
        tick();
        rst = 0;
      end else if (r < 75) begin
        if (m_state == 1 && $urandom_range(0, 9) != 0) send_entry(m_ptr, 9'($urandom));
        else send({$urandom, $urandom}, 8'($urandom), 16'($urandom), 9'($urandom));
      end else begin
        tick();
      end
    end
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
